cmd_ascii_tx: RTL and testbench

- Transmit-side counterpart of the keyboard command decoder. It takes single-cycle command pulses (D, E, B, F, R) from the player control logic and re-encodes them as an ASCII character stream, optionally followed by CR LF.
- Output is a byte-wide valid/ready stream that feeds the LCD/UART echo path for the user display.
- A small command FIFO absorbs bursts while the sink applies backpressure.

---
 rtl/cmd_pkg.sv | 45 ++++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/cmd_ascii_tx.sv | 125 ++++++++++++
 tb/tb_cmd_ascii_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared command codes, ASCII constants and transmit FSM states for the
// command-to-ASCII echo path.
package cmd_pkg;

  typedef enum logic [2:0] {
    CMD_D = 3'd0,
    CMD_E = 3'd1,
    CMD_B = 3'd2,
    CMD_F = 3'd3,
    CMD_R = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHAR,
    ST_CR,
    ST_LF
  } tx_state_t;

  localparam logic [7:0] ASCII_D_UC = 8'h44;
  localparam logic [7:0] ASCII_E_UC = 8'h45;
  localparam logic [7:0] ASCII_B_UC = 8'h42;
  localparam logic [7:0] ASCII_F_UC = 8'h46;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_D_LC = 8'h64;
  localparam logic [7:0] ASCII_E_LC = 8'h65;
  localparam logic [7:0] ASCII_B_LC = 8'h62;
  localparam logic [7:0] ASCII_F_LC = 8'h66;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic [7:0] cmd_to_ascii(input cmd_t cmd, input logic upper);
    logic [7:0] ch;
    case (cmd)
      CMD_D:   ch = upper ? ASCII_D_UC : ASCII_D_LC;
      CMD_E:   ch = upper ? ASCII_E_UC : ASCII_E_LC;
      CMD_B:   ch = upper ? ASCII_B_UC : ASCII_B_LC;
      CMD_F:   ch = upper ? ASCII_F_UC : ASCII_F_LC;
      default: ch = upper ? ASCII_R_UC : ASCII_R_LC;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cmd_ascii_tx.sv
// Queues single-cycle command pulses and replays them as ASCII letters,
// optionally followed by CR LF, on a registered valid/ready byte stream.
module cmd_ascii_tx
  import cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit UPPER      = 1'b1,
  parameter bit TERM_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_d,
  input  logic       cmd_e,
  input  logic       cmd_b,
  input  logic       cmd_f,
  input  logic       cmd_r,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       overflow,
  input  logic       clr_overflow
);

  tx_state_t  state_q;
  logic [7:0] char_out_q;
  logic       char_valid_q;
  logic       overflow_q, overflow_d;
  cmd_t       cmd_sel;
  logic       cmd_any;
  logic [2:0] fifo_dout;
  logic       fifo_full, fifo_empty;
  logic       fifo_pop, drop, handshake;

  assign cmd_any = cmd_d | cmd_e | cmd_b | cmd_f | cmd_r;

  always_comb begin
    cmd_sel = CMD_R;
    if (cmd_d)      cmd_sel = CMD_D;
    else if (cmd_e) cmd_sel = CMD_E;
    else if (cmd_b) cmd_sel = CMD_B;
    else if (cmd_f) cmd_sel = CMD_F;
  end

  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign drop      = cmd_any && fifo_full && !fifo_pop;
  assign handshake = char_valid_q && char_ready;

  cmd_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_any),
    .din   (cmd_sel),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A new drop takes precedence over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            char_out_q   <= cmd_to_ascii(cmd_t'(fifo_dout), UPPER);
            char_valid_q <= 1'b1;
            state_q      <= ST_CHAR;
          end
        end
        ST_CHAR: begin
          if (handshake) begin
            if (TERM_EN) begin
              char_out_q <= ASCII_CR;
              state_q    <= ST_CR;
            end else begin
              char_valid_q <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end
        end
        ST_CR: begin
          if (handshake) begin
            char_out_q <= ASCII_LF;
            state_q    <= ST_LF;
          end
        end
        ST_LF: begin
          if (handshake) begin
            char_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          char_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign overflow   = overflow_q;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_ascii_tx.sv
// Directed bench: three configurations (upper+CRLF, lower+CRLF, upper only)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_cmd_ascii_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_d, cmd_e, cmd_b, cmd_f, cmd_r;
  logic       char_ready;
  logic       clr_overflow;
  logic [7:0] char_out_w   [3];
  logic       char_valid_w [3];
  logic       busy_w       [3];
  logic       overflow_w   [3];

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  cmd_ascii_tx #(.FIFO_DEPTH(4), .UPPER(1'b1), .TERM_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_d(cmd_d), .cmd_e(cmd_e), .cmd_b(cmd_b),
    .cmd_f(cmd_f), .cmd_r(cmd_r), .char_out(char_out_w[0]),
    .char_valid(char_valid_w[0]), .char_ready(char_ready), .busy(busy_w[0]),
    .overflow(overflow_w[0]), .clr_overflow(clr_overflow)
  );

  cmd_ascii_tx #(.FIFO_DEPTH(4), .UPPER(1'b0), .TERM_EN(1'b1)) u_lower (
    .clk(clk), .rst_n(rst_n), .cmd_d(cmd_d), .cmd_e(cmd_e), .cmd_b(cmd_b),
    .cmd_f(cmd_f), .cmd_r(cmd_r), .char_out(char_out_w[1]),
    .char_valid(char_valid_w[1]), .char_ready(char_ready), .busy(busy_w[1]),
    .overflow(overflow_w[1]), .clr_overflow(clr_overflow)
  );

  cmd_ascii_tx #(.FIFO_DEPTH(4), .UPPER(1'b1), .TERM_EN(1'b0)) u_noterm (
    .clk(clk), .rst_n(rst_n), .cmd_d(cmd_d), .cmd_e(cmd_e), .cmd_b(cmd_b),
    .cmd_f(cmd_f), .cmd_r(cmd_r), .char_out(char_out_w[2]),
    .char_valid(char_valid_w[2]), .char_ready(char_ready), .busy(busy_w[2]),
    .overflow(overflow_w[2]), .clr_overflow(clr_overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Samples and drives land 1 time unit after the rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // cmds = {d, e, b, f, r}; the pulse is sampled by the next rising edge.
  task automatic applyStimulus(input logic [4:0] cmds);
    {cmd_d, cmd_e, cmd_b, cmd_f, cmd_r} = cmds;
    waitCycle();
    {cmd_d, cmd_e, cmd_b, cmd_f, cmd_r} = 5'b00000;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) waitCycle();
  endtask

  task automatic collectStream(input int inst, input int max_cycles);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      if (char_valid_w[inst] && char_ready)
        checkOutput("stream byte", char_out_w[inst], exp_q.pop_front());
      waitCycle();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("stream timeout (bytes left)", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad_valid;
    rst_n = 1'b0;
    char_ready = 1'b1;
    clr_overflow = 1'b0;
    {cmd_d, cmd_e, cmd_b, cmd_f, cmd_r} = 5'b00000;
    #1;
    checkOutput("reset char_valid", char_valid_w[0], 0);
    checkOutput("reset char_out", char_out_w[0], 8'h00);
    checkOutput("reset busy", busy_w[0], 0);
    checkOutput("reset overflow", overflow_w[0], 0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(2);

    // Single D, uppercase with CR LF, ready always high
    applyStimulus(5'b10000);
    checkOutput("D latency valid low", char_valid_w[0], 0);
    checkOutput("D queued busy", busy_w[0], 1);
    waitCycle();
    checkOutput("D valid", char_valid_w[0], 1);
    checkOutput("D letter", char_out_w[0], 8'h44);
    waitCycle();
    checkOutput("D CR", char_out_w[0], 8'h0D);
    checkOutput("D CR valid", char_valid_w[0], 1);
    waitCycle();
    checkOutput("D LF", char_out_w[0], 8'h0A);
    waitCycle();
    checkOutput("D done valid", char_valid_w[0], 0);
    checkOutput("D done busy", busy_w[0], 0);
    idleCycles(3);

    // Lowercase F held under backpressure
    char_ready = 1'b0;
    applyStimulus(5'b00010);
    waitCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("f held valid", char_valid_w[1], 1);
      checkOutput("f held letter", char_out_w[1], 8'h66);
      waitCycle();
    end
    char_ready = 1'b1;
    checkOutput("f before accept", char_out_w[1], 8'h66);
    waitCycle();
    checkOutput("f CR", char_out_w[1], 8'h0D);
    waitCycle();
    checkOutput("f LF", char_out_w[1], 8'h0A);
    waitCycle();
    checkOutput("f done valid", char_valid_w[1], 0);
    idleCycles(3);

    // E and B together: priority keeps only E
    applyStimulus(5'b01100);
    waitCycle();
    checkOutput("E+B letter", char_out_w[0], 8'h45);
    waitCycle();
    checkOutput("E+B CR", char_out_w[0], 8'h0D);
    waitCycle();
    checkOutput("E+B LF", char_out_w[0], 8'h0A);
    waitCycle();
    checkOutput("E+B done valid", char_valid_w[0], 0);
    checkOutput("E+B nothing queued", busy_w[0], 0);
    checkOutput("E+B overflow", overflow_w[0], 0);
    idleCycles(3);

    // Burst of six into a depth-4 FIFO while the sink stalls
    char_ready = 1'b0;
    applyStimulus(5'b10000);
    applyStimulus(5'b01000);
    applyStimulus(5'b00100);
    applyStimulus(5'b00010);
    applyStimulus(5'b00001);
    checkOutput("burst full no overflow yet", overflow_w[0], 0);
    applyStimulus(5'b10000);
    checkOutput("burst overflow set", overflow_w[0], 1);
    char_ready = 1'b1;
    exp_q = '{8'h44, 8'h0D, 8'h0A, 8'h45, 8'h0D, 8'h0A, 8'h42, 8'h0D, 8'h0A,
              8'h46, 8'h0D, 8'h0A, 8'h52, 8'h0D, 8'h0A};
    collectStream(0, 60);
    checkOutput("burst drained busy", busy_w[0], 0);
    checkOutput("burst overflow sticky", overflow_w[0], 1);
    clr_overflow = 1'b1;
    waitCycle();
    clr_overflow = 1'b0;
    checkOutput("burst overflow cleared", overflow_w[0], 0);
    idleCycles(3);

    // Drop coinciding with clear: the set must win
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(5'b10000);
    checkOutput("drop+clr pre", overflow_w[0], 0);
    clr_overflow = 1'b1;
    applyStimulus(5'b10000);
    clr_overflow = 1'b0;
    checkOutput("drop+clr set wins", overflow_w[0], 1);
    char_ready = 1'b1;
    idleCycles(40);
    clr_overflow = 1'b1;
    waitCycle();
    clr_overflow = 1'b0;
    checkOutput("drop+clr cleared", overflow_w[0], 0);
    idleCycles(3);

    // No terminator: R then D three cycles apart (FIFO empty between them)
    applyStimulus(5'b00001);
    checkOutput("noterm R not yet", char_valid_w[2], 0);
    waitCycle();
    checkOutput("noterm R letter", char_out_w[2], 8'h52);
    checkOutput("noterm R valid", char_valid_w[2], 1);
    waitCycle();
    checkOutput("noterm idle after R", char_valid_w[2], 0);
    applyStimulus(5'b10000);
    checkOutput("noterm idle before D", char_valid_w[2], 0);
    waitCycle();
    checkOutput("noterm D letter", char_out_w[2], 8'h44);
    waitCycle();
    checkOutput("noterm D done", char_valid_w[2], 0);
    idleCycles(6);

    // No terminator: R and D back to back, exactly one gap cycle
    applyStimulus(5'b00001);
    applyStimulus(5'b10000);
    checkOutput("b2b R letter", char_out_w[2], 8'h52);
    checkOutput("b2b R valid", char_valid_w[2], 1);
    waitCycle();
    checkOutput("b2b gap", char_valid_w[2], 0);
    waitCycle();
    checkOutput("b2b D letter", char_out_w[2], 8'h44);
    checkOutput("b2b D valid", char_valid_w[2], 1);
    waitCycle();
    checkOutput("b2b end valid", char_valid_w[2], 0);
    checkOutput("b2b end busy", busy_w[2], 0);
    idleCycles(6);

    // Asynchronous reset while CR is pending, with another command queued
    applyStimulus(5'b10000);
    waitCycle();
    checkOutput("rst pre letter", char_out_w[0], 8'h44);
    waitCycle();
    char_ready = 1'b0;
    applyStimulus(5'b01000);
    checkOutput("rst pre CR", char_out_w[0], 8'h0D);
    checkOutput("rst pre valid", char_valid_w[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async valid", char_valid_w[0], 0);
    checkOutput("rst async busy", busy_w[0], 0);
    checkOutput("rst async char_out", char_out_w[0], 8'h00);
    #4;
    rst_n = 1'b1;
    char_ready = 1'b1;
    waitCycle();
    bad_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (char_valid_w[0]) bad_valid++;
      waitCycle();
    end
    checkOutput("rst no resume valid cycles", bad_valid, 0);
    checkOutput("rst fifo empty", busy_w[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
